// File: rtl/invaders_irq_timer.sv
// Raster counter and RST 1 / RST 2 interrupt generator for the Space Invaders i8080.
// Events latch into pending bits that are presented to the CPU with vblank priority.
module invaders_irq_timer #(
    parameter int H_TOTAL      = 320,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 272,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_TOTAL      = 262,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 234,
    parameter int V_SYNC_LEN   = 4,
    parameter int MID_LINE     = 96,
    parameter int VBL_LINE     = 224
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    input  logic        int_en,
    input  logic        int_ack,
    output logic        int_req,
    output logic [7:0]  int_vec,
    output logic [8:0]  hcount,
    output logic [8:0]  vcount,
    output logic [12:0] vram_off,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [7:0]  ovf_cnt
);

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0] HS_FIRST = 9'(H_SYNC_START);
    localparam logic [8:0] HS_END   = 9'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [8:0] VS_FIRST = 9'(V_SYNC_START);
    localparam logic [8:0] VS_END   = 9'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [8:0] MID_L    = 9'(MID_LINE);
    localparam logic [8:0] VBL_L    = 9'(VBL_LINE);

    localparam logic [7:0] VEC_RST1 = 8'hCF;
    localparam logic [7:0] VEC_RST2 = 8'hD7;
    localparam logic [7:0] VEC_NOP  = 8'h00;

    logic [8:0] hcount_q, hcount_d;
    logic [8:0] vcount_q, vcount_d;
    logic       pendMid_q, pendMid_d;
    logic       pendVbl_q, pendVbl_d;
    logic [7:0] ovf_q, ovf_d;

    logic       lineStart;
    logic       evtMid, evtVbl;
    logic       ackMid, ackVbl;
    logic       ovfMid, ovfVbl;
    logic [8:0] ovfSum;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_ce) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 9'd0;
                vcount_d = (vcount_q == V_LAST) ? 9'd0 : vcount_q + 9'd1;
            end else begin
                hcount_d = hcount_q + 9'd1;
            end
        end
    end

    // An event needs pix_ce, so the counter moves off (0,line) on the same edge and cannot re-fire.
    assign lineStart = pix_ce && (hcount_q == 9'd0);
    assign evtMid    = lineStart && (vcount_q == MID_L);
    assign evtVbl    = lineStart && (vcount_q == VBL_L);

    assign ackVbl = int_ack & pendVbl_q;
    assign ackMid = int_ack & ~pendVbl_q & pendMid_q;

    assign ovfMid = evtMid & pendMid_q & ~ackMid;
    assign ovfVbl = evtVbl & pendVbl_q & ~ackVbl;

    always_comb begin
        pendMid_d = evtMid | (pendMid_q & ~ackMid);
        pendVbl_d = evtVbl | (pendVbl_q & ~ackVbl);
        ovfSum    = {1'b0, ovf_q} + {8'd0, ovfMid} + {8'd0, ovfVbl};
        ovf_d     = (ovfSum > 9'd255) ? 8'hFF : ovfSum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q  <= 9'd0;
            vcount_q  <= 9'd0;
            pendMid_q <= 1'b0;
            pendVbl_q <= 1'b0;
            ovf_q     <= 8'd0;
        end else begin
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            pendMid_q <= pendMid_d;
            pendVbl_q <= pendVbl_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        if (pendVbl_q) begin
            int_vec = VEC_RST2;
        end else if (pendMid_q) begin
            int_vec = VEC_RST1;
        end else begin
            int_vec = VEC_NOP;
        end
    end

    assign int_req  = int_en & (pendMid_q | pendVbl_q);
    assign hcount   = hcount_q;
    assign vcount   = vcount_q;
    assign vram_off = {vcount_q[7:0], hcount_q[7:3]};
    assign hsync    = (hcount_q >= HS_FIRST) && (hcount_q < HS_END);
    assign vsync    = (vcount_q >= VS_FIRST) && (vcount_q < VS_END);
    assign blank    = (hcount_q >= H_ACT) || (vcount_q >= V_ACT);
    assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_invaders_irq_timer.sv
// Scoreboard bench for invaders_irq_timer, run on a shrunken raster (20x12) so whole frames fit
// in a short simulation; event lines and sync windows scale with it.
module tb_invaders_irq_timer;

    localparam int HT  = 20;
    localparam int HA  = 16;
    localparam int HSS = 17;
    localparam int HSL = 2;
    localparam int VT  = 12;
    localparam int VA  = 9;
    localparam int VSS = 10;
    localparam int VSL = 1;
    localparam int ML  = 4;
    localparam int VL  = 9;
    localparam int FRAME = HT * VT;

    localparam int SIG_H    = 0;
    localparam int SIG_V    = 1;
    localparam int SIG_REQ  = 2;
    localparam int SIG_VEC  = 3;
    localparam int SIG_HS   = 4;
    localparam int SIG_VS   = 5;
    localparam int SIG_BL   = 6;
    localparam int SIG_OFF  = 7;
    localparam int SIG_OVF  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_ce;
    logic        int_en;
    logic        int_ack;
    logic        int_req;
    logic [7:0]  int_vec;
    logic [8:0]  hcount;
    logic [8:0]  vcount;
    logic [12:0] vram_off;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [7:0]  ovf_cnt;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    item_t it;
    int    total = 0;
    int    bad   = 0;

    invaders_irq_timer #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
        .MID_LINE(ML), .VBL_LINE(VL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .int_en(int_en), .int_ack(int_ack),
        .int_req(int_req), .int_vec(int_vec), .hcount(hcount), .vcount(vcount),
        .vram_off(vram_off), .hsync(hsync), .vsync(vsync), .blank(blank), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    function automatic void pushExp(input string name, input int sig, input logic [31:0] exp);
        item_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb.push_back(e);
    endfunction

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            SIG_H:   return 32'(hcount);
            SIG_V:   return 32'(vcount);
            SIG_REQ: return 32'(int_req);
            SIG_VEC: return 32'(int_vec);
            SIG_HS:  return 32'(hsync);
            SIG_VS:  return 32'(vsync);
            SIG_BL:  return 32'(blank);
            SIG_OFF: return 32'(vram_off);
            default: return 32'(ovf_cnt);
        endcase
    endfunction

    // One clock with the given inputs held across the edge; returns 1 time unit after the edge.
    task automatic stepClk(input logic ce, input logic ack);
        pix_ce  = ce;
        int_ack = ack;
        @(posedge clk);
        #1;
        pix_ce  = 1'b0;
        int_ack = 1'b0;
    endtask

    task automatic runPulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) stepClk(1'b0, 1'b0);
            stepClk(1'b1, 1'b0);
        end
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        pix_ce  = 1'b0;
        int_en  = 1'b0;
        int_ack = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        pix_ce  = 1'b0;
        int_en  = 1'b0;
        int_ack = 1'b0;
        #2;
        pushExp("rst hcount", SIG_H, 0);
        pushExp("rst vcount", SIG_V, 0);
        pushExp("rst int_req", SIG_REQ, 0);
        pushExp("rst int_vec", SIG_VEC, 0);
        pushExp("rst hsync", SIG_HS, 0);
        pushExp("rst vsync", SIG_VS, 0);
        pushExp("rst blank", SIG_BL, 0);
        pushExp("rst vram_off", SIG_OFF, 0);
        pushExp("rst ovf_cnt", SIG_OVF, 0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame();
        int h;
        int v;
        for (int p = 0; p <= FRAME; p++) begin
            h = p % HT;
            v = (p / HT) % VT;
            pushExp($sformatf("frame p%0d hcount", p), SIG_H, 32'(h));
            pushExp($sformatf("frame p%0d vcount", p), SIG_V, 32'(v));
            pushExp($sformatf("frame p%0d hsync", p), SIG_HS, 32'((h >= HSS) && (h < HSS + HSL)));
            pushExp($sformatf("frame p%0d vsync", p), SIG_VS, 32'((v >= VSS) && (v < VSS + VSL)));
            pushExp($sformatf("frame p%0d blank", p), SIG_BL, 32'((h >= HA) || (v >= VA)));
            pushExp($sformatf("frame p%0d vram_off", p), SIG_OFF, 32'(v * 32 + h / 8));
            while (sb.size() != 0) begin
                it = sb.pop_front();
                total++;
                if (sample(it.sig) !== it.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
                end
            end
            if (p < FRAME) stepClk(1'b1, 1'b0);
        end
        pushExp("frame masked int_req", SIG_REQ, 0);
        pushExp("frame both pending vec", SIG_VEC, 32'hD7);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
    endtask

    task automatic test_mid();
        doReset();
        int_en = 1'b1;
        runPulses(ML * HT, 4);
        pushExp("mid at line start hcount", SIG_H, 0);
        pushExp("mid at line start vcount", SIG_V, 32'(ML));
        pushExp("mid before event int_req", SIG_REQ, 0);
        repeat (4) stepClk(1'b0, 1'b0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        pushExp("mid int_req", SIG_REQ, 1);
        pushExp("mid int_vec", SIG_VEC, 32'hCF);
        stepClk(1'b1, 1'b0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        pushExp("mid held int_req", SIG_REQ, 1);
        repeat (3) stepClk(1'b0, 1'b0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        pushExp("mid acked int_req", SIG_REQ, 0);
        pushExp("mid acked int_vec", SIG_VEC, 0);
        pushExp("mid ovf_cnt", SIG_OVF, 0);
        stepClk(1'b0, 1'b1);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
    endtask

    task automatic test_priority();
        doReset();
        runPulses(VL * HT + 1, 0);
        pushExp("prio masked int_req", SIG_REQ, 0);
        pushExp("prio pending vec", SIG_VEC, 32'hD7);
        pushExp("prio hcount", SIG_H, 1);
        pushExp("prio vcount", SIG_V, 32'(VL));
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        int_en = 1'b1;
        #1;
        pushExp("prio enabled int_req", SIG_REQ, 1);
        pushExp("prio first vec", SIG_VEC, 32'hD7);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        pushExp("prio second int_req", SIG_REQ, 1);
        pushExp("prio second vec", SIG_VEC, 32'hCF);
        stepClk(1'b0, 1'b1);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        pushExp("prio drained int_req", SIG_REQ, 0);
        pushExp("prio drained vec", SIG_VEC, 0);
        stepClk(1'b0, 1'b1);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        pushExp("idle ack int_req", SIG_REQ, 0);
        pushExp("idle ack vec", SIG_VEC, 0);
        pushExp("idle ack ovf_cnt", SIG_OVF, 0);
        stepClk(1'b0, 1'b1);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
    endtask

    task automatic test_overrun();
        doReset();
        runPulses(3 * FRAME, 0);
        pushExp("ovr ovf_cnt after 3 frames", SIG_OVF, 4);
        pushExp("ovr masked int_req", SIG_REQ, 0);
        pushExp("ovr hcount", SIG_H, 0);
        pushExp("ovr vcount", SIG_V, 0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        int_en = 1'b1;
        #1;
        pushExp("ovr enabled int_req", SIG_REQ, 1);
        pushExp("ovr enabled vec", SIG_VEC, 32'hD7);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        // Two overruns per further frame: 4 + 2*125 = 254, then saturation at 255.
        pushExp("ovr ovf_cnt 254", SIG_OVF, 254);
        runPulses(125 * FRAME, 0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        for (int f = 0; f < 2; f++) begin
            pushExp($sformatf("ovr saturated frame %0d", f), SIG_OVF, 255);
            runPulses(FRAME, 0);
            while (sb.size() != 0) begin
                it = sb.pop_front();
                total++;
                if (sample(it.sig) !== it.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
                end
            end
        end
    endtask

    task automatic test_collision();
        doReset();
        int_en = 1'b1;
        runPulses(ML * HT + 1, 0);
        pushExp("coll mid vec", SIG_VEC, 32'hCF);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        stepClk(1'b0, 1'b1);
        runPulses((VL - ML) * HT, 0);
        runPulses(FRAME - 1, 0);
        pushExp("coll pre hcount", SIG_H, 0);
        pushExp("coll pre vcount", SIG_V, 32'(VL));
        pushExp("coll pre vec", SIG_VEC, 32'hD7);
        pushExp("coll pre ovf_cnt", SIG_OVF, 0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        pushExp("coll vbl retained vec", SIG_VEC, 32'hD7);
        pushExp("coll int_req", SIG_REQ, 1);
        pushExp("coll ovf_cnt", SIG_OVF, 0);
        pushExp("coll hcount", SIG_H, 1);
        stepClk(1'b1, 1'b1);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        pushExp("coll then mid vec", SIG_VEC, 32'hCF);
        stepClk(1'b0, 1'b1);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        pushExp("coll drained int_req", SIG_REQ, 0);
        stepClk(1'b0, 1'b1);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
    endtask

    task automatic test_reset_midframe();
        doReset();
        int_en = 1'b1;
        runPulses(6 * HT + 5, 0);
        pushExp("midrst pre int_req", SIG_REQ, 1);
        pushExp("midrst pre hcount", SIG_H, 5);
        pushExp("midrst pre vcount", SIG_V, 6);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        pushExp("midrst async int_req", SIG_REQ, 0);
        pushExp("midrst async int_vec", SIG_VEC, 0);
        pushExp("midrst async hcount", SIG_H, 0);
        pushExp("midrst async vcount", SIG_V, 0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
        #2;
        rst_n = 1'b1;
        pushExp("midrst restart hcount", SIG_H, 1);
        pushExp("midrst restart vcount", SIG_V, 0);
        pushExp("midrst restart int_req", SIG_REQ, 0);
        stepClk(1'b1, 1'b0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            total++;
            if (sample(it.sig) !== it.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", it.name, sample(it.sig), it.exp);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        pix_ce  = 1'b0;
        int_en  = 1'b0;
        int_ack = 1'b0;
        #1;
        test_reset();
        test_frame();
        test_mid();
        test_priority();
        test_overrun();
        test_collision();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
